hmi_joy_mapper: RTL and testbench

HMI_JOY_MAPPER -- requirements
Module: hmi_joy_mapper

---
 rtl/hmi_pkg.sv | 78 +++++++
 rtl/hmi_joy_mapper_turbo_gen.sv | 40 ++++
 rtl/hmi_joy_mapper.sv | 87 ++++++++
 tb/tb_hmi_joy_mapper.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmi_pkg.sv
// hmi_pkg: shared types, joystick bit positions and the per-port mapping
// function for the HMI joystick mapper.
//   joypad_t : one mapped pad as seen by the core
//   hmi_t    : frame-wide controls applied to every port's mapping
package hmi_pkg;

    localparam int unsigned JOY_W      = 32;
    localparam int unsigned RATE_W     = 2;
    localparam int unsigned FRAME_CNT_W = 3;

    // Raw HPS joystick word bit positions
    localparam int unsigned JOY_R      = 0;
    localparam int unsigned JOY_L      = 1;
    localparam int unsigned JOY_D      = 2;
    localparam int unsigned JOY_U      = 3;
    localparam int unsigned JOY_B1     = 4;
    localparam int unsigned JOY_B2     = 5;
    localparam int unsigned JOY_SELECT = 6;
    localparam int unsigned JOY_RUN    = 7;
    localparam int unsigned JOY_B3     = 8;
    localparam int unsigned JOY_B4     = 9;
    localparam int unsigned JOY_B5     = 10;
    localparam int unsigned JOY_B6     = 11;
    localparam int unsigned JOY_TURBO1 = 12;
    localparam int unsigned JOY_TURBO2 = 13;
    // Bits at and above this position carry nothing for the mapper
    localparam int unsigned JOY_USED_W = 14;

    typedef struct packed {
        logic mode2;
        logic mode1;
        logic run;
        logic select;
        logic b6;
        logic b5;
        logic b4;
        logic b3;
        logic b2;
        logic b1;
        logic u;
        logic d;
        logic l;
        logic r;
    } joypad_t;

    typedef struct packed {
        logic socd_clean;
        logic turbo_phase;
    } hmi_t;

    // Map one raw joystick word to a pad
    function automatic joypad_t map_pad(input logic [JOY_W-1:0] joy,
                                        input logic             six,
                                        input hmi_t             ctl);
        joypad_t p;
        logic    opp_ud;
        logic    opp_lr;
        p      = '0;
        opp_ud = ctl.socd_clean & joy[JOY_U] & joy[JOY_D];
        opp_lr = ctl.socd_clean & joy[JOY_L] & joy[JOY_R];
        p.u      = joy[JOY_U] & ~opp_ud;
        p.d      = joy[JOY_D] & ~opp_ud;
        p.l      = joy[JOY_L] & ~opp_lr;
        p.r      = joy[JOY_R] & ~opp_lr;
        p.b1     = joy[JOY_B1] | (joy[JOY_TURBO1] & ctl.turbo_phase);
        p.b2     = joy[JOY_B2] | (joy[JOY_TURBO2] & ctl.turbo_phase);
        p.select = joy[JOY_SELECT];
        p.run    = joy[JOY_RUN];
        p.b3     = joy[JOY_B3] & six;
        p.b4     = joy[JOY_B4] & six;
        p.b5     = joy[JOY_B5] & six;
        p.b6     = joy[JOY_B6] & six;
        p.mode1  = 1'b0;
        p.mode2  = six;
        return p;
    endfunction

endpackage

// File: rtl/hmi_joy_mapper_turbo_gen.sv
// hmi_turbo_gen: free-running 3-bit frame counter advanced on each VSync
// edge, and the turbo square-wave phase selected from it.
//   clk_sys    : clock
//   reset      : synchronous active-high reset
//   vsync_edge : one-cycle VSync rising-edge strobe
//   rate       : 0 = off, 1/2/3 = period of 2/4/8 frames
//   phase      : current turbo phase (from the counter before this edge)
module hmi_turbo_gen
    import hmi_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vsync_edge,
    input  logic [RATE_W-1:0] rate,
    output logic              phase
);

    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    // Frame counter, wraps 7 -> 0 naturally
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (vsync_edge) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
        end
    end

    // Phase select: rate n picks counter bit n-1
    always_comb begin
        phase = 1'b0;
        case (rate)
            2'd1:    phase = r_frame_cnt[0];
            2'd2:    phase = r_frame_cnt[1];
            2'd3:    phase = r_frame_cnt[2];
            default: phase = 1'b0;
        endcase
    end

endmodule

// File: rtl/hmi_joy_mapper.sv
// hmi_joy_mapper: maps raw HPS joystick words to registered joypad_t pads,
// with optional SOCD cleaning, 6-button gating and VSync-latched update.
// Build option: define HMI_TURBO_EN to compile in the frame counter and
// turbo autofire (joy[12]/joy[13]); otherwise turbo_phase is 0.
//   clk_sys     : clock
//   reset       : synchronous active-high reset
//   joystick    : NUM_PORTS raw 32-bit words
//   six_btn     : per-port 6-button enable
//   socd_clean  : neutralise opposing directions
//   turbo_rate  : 0 = off, 1/2/3 = 2/4/8-frame turbo period
//   vsync       : frame strobe
//   jp          : registered mapped pads
//   turbo_phase : current turbo phase
module hmi_joy_mapper
    import hmi_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter bit          VSYNC_LATCH = 1'b1
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0][JOY_W-1:0]   joystick,
    input  logic [NUM_PORTS-1:0]              six_btn,
    input  logic                              socd_clean,
    input  logic [RATE_W-1:0]                 turbo_rate,
    input  logic                              vsync,
    output joypad_t [NUM_PORTS-1:0]           jp,
    output logic                              turbo_phase
);

    logic                    r_vsync_d;
    logic                    w_vsync_edge;
    logic                    w_turbo_phase;
    logic                    w_load;
    hmi_t                    w_ctl;
    joypad_t [NUM_PORTS-1:0] w_mapped;
    joypad_t [NUM_PORTS-1:0] r_jp;

    // VSync rising-edge detect; a held-high vsync yields a single edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
        end
    end

    assign w_vsync_edge = vsync & ~r_vsync_d;

`ifdef HMI_TURBO_EN
    hmi_turbo_gen u_turbo_gen (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .vsync_edge (w_vsync_edge),
        .rate       (turbo_rate),
        .phase      (w_turbo_phase)
    );
`else
    logic w_unused_rate;
    assign w_unused_rate = ^turbo_rate;
    assign w_turbo_phase = 1'b0;
`endif

    assign w_ctl = '{socd_clean: socd_clean, turbo_phase: w_turbo_phase};

    // Per-port combinational mapping
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic w_unused_hi;
        assign w_mapped[g]  = map_pad(joystick[g], six_btn[g], w_ctl);
        assign w_unused_hi  = ^joystick[g][JOY_W-1:JOY_USED_W];
    end

    // Load every cycle, or only on the VSync edge when latching
    assign w_load = (VSYNC_LATCH == 1'b0) || w_vsync_edge;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_jp <= '0;
        end else if (w_load) begin
            r_jp <= w_mapped;
        end
    end

    assign jp          = r_jp;
    assign turbo_phase = w_turbo_phase;

endmodule

// File: tb/tb_hmi_joy_mapper.sv
module tb_hmi_joy_mapper;
    import hmi_pkg::*;

    localparam int unsigned NP = 2;
`ifdef HMI_TURBO_EN
    localparam bit TURBO = 1'b1;
`else
    localparam bit TURBO = 1'b0;
`endif

    logic                   clk_sys = 1'b0;
    logic                   reset;
    logic [NP-1:0][31:0]    joystick;
    logic [NP-1:0]          six_btn;
    logic                   socd_clean;
    logic [1:0]             turbo_rate;
    logic                   vsync;
    joypad_t [NP-1:0]       jp;
    joypad_t [NP-1:0]       jp_nl;
    logic                   turbo_phase;
    logic                   turbo_phase_nl;

    always #5 clk_sys = ~clk_sys;

    hmi_joy_mapper #(.NUM_PORTS(NP), .VSYNC_LATCH(1'b1)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .joystick    (joystick),
        .six_btn     (six_btn),
        .socd_clean  (socd_clean),
        .turbo_rate  (turbo_rate),
        .vsync       (vsync),
        .jp          (jp),
        .turbo_phase (turbo_phase)
    );

    hmi_joy_mapper #(.NUM_PORTS(NP), .VSYNC_LATCH(1'b0)) dut_nl (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .joystick    (joystick),
        .six_btn     (six_btn),
        .socd_clean  (socd_clean),
        .turbo_rate  (turbo_rate),
        .vsync       (vsync),
        .jp          (jp_nl),
        .turbo_phase (turbo_phase_nl)
    );

    // Scoreboard entry: kind 0 = latched jp, 1 = every-cycle jp, 2 = turbo_phase
    typedef struct {
        int          due;
        int          kind;
        int          port;
        logic [13:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic void push(int dly, int kind, int port, logic [13:0] v, string name);
        chk_t c;
        c.due  = cyc + dly;
        c.kind = kind;
        c.port = port;
        c.exp  = v;
        c.name = name;
        q.push_back(c);
    endfunction

    function automatic void exp_jp(int dly, int port, joypad_t e, string name);
        push(dly, 0, port, e, name);
    endfunction

    function automatic void exp_nl(int dly, int port, joypad_t e, string name);
        push(dly, 1, port, e, name);
    endfunction

    function automatic void exp_ph(int dly, logic e, string name);
        push(dly, 2, 0, {13'd0, e}, name);
    endfunction

    // Monitor: compares every due entry at the falling edge
    always @(negedge clk_sys) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            chk_t        c;
            logic [13:0] act;
            c = q.pop_front();
            case (c.kind)
                0:       act = jp[c.port];
                1:       act = jp_nl[c.port];
                default: act = {13'd0, turbo_phase};
            endcase
            n_checks++;
            if (c.due < cyc) begin
                n_fail++;
                $display("FAIL %s: check missed, due cycle %0d, now %0d", c.name, c.due, cyc);
            end else if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: cycle %0d actual 14'h%04h required 14'h%04h",
                         c.name, cyc, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    joypad_t    e;
    logic [3:0] pat;
    logic [1:0] pat1;
    logic [3:0] nl_vals;

    initial begin
        reset      = 1'b1;
        joystick   = '0;
        six_btn    = '0;
        socd_clean = 1'b0;
        turbo_rate = 2'd1;
        vsync      = 1'b0;
        tick();
        tick();

        // Reset state
        exp_jp(0, 0, '0, "rst_jp0");
        exp_jp(0, 1, '0, "rst_jp1");
        exp_ph(0, 1'b0, "rst_phase");
        exp_nl(0, 0, '0, "rst_nl_jp0");
        tick();
        reset      = 1'b0;
        turbo_rate = 2'd0;
        tick();
        tick();

        // First edge after reset: b1 loads one cycle after the edge (fc 0->1)
        joystick[0] = 32'h0000_0010;
        exp_jp(0, 0, '0, "pre_edge_jp0");
        exp_nl(0, 0, '0, "nl_old_value");
        e = '0; e.b1 = 1'b1;
        exp_nl(1, 0, e, "nl_one_cycle");
        tick();
        exp_jp(0, 0, '0, "pre_edge_still0");
        exp_jp(1, 0, e, "edge_b1");
        exp_jp(1, 1, '0, "edge_jp1");
        vs_pulse();

        // Hold between edges, then next edge loads b2 (fc 1->2)
        joystick[0] = 32'h0000_0020;
        tick();
        tick();
        exp_jp(0, 0, e, "hold_between_edges");
        e = '0; e.b2 = 1'b1;
        exp_jp(1, 0, e, "edge_b2");
        vs_pulse();

        // SOCD cleaning (fc 2->3->4->5)
        socd_clean  = 1'b1;
        joystick[0] = 32'h0000_0003;
        joystick[1] = 32'h0000_000C;
        exp_jp(1, 0, '0, "socd_lr_cleared");
        exp_jp(1, 1, '0, "socd_ud_cleared");
        vs_pulse();
        socd_clean = 1'b0;
        e = '0; e.l = 1'b1; e.r = 1'b1;
        exp_jp(1, 0, e, "nosocd_lr");
        e = '0; e.u = 1'b1; e.d = 1'b1;
        exp_jp(1, 1, e, "nosocd_ud");
        vs_pulse();
        socd_clean  = 1'b1;
        joystick[0] = 32'h0000_000E;
        joystick[1] = 32'h0000_0009;
        e = '0; e.l = 1'b1;
        exp_jp(1, 0, e, "socd_ud_only");
        e = '0; e.u = 1'b1; e.r = 1'b1;
        exp_jp(1, 1, e, "socd_non_opposing");
        vs_pulse();
        socd_clean = 1'b0;

        // Six-button gating (fc 5->6->7)
        six_btn     = 2'b01;
        joystick[0] = 32'h0000_0F00;
        joystick[1] = 32'h0000_0F00;
        e = '0; e.b3 = 1'b1; e.b4 = 1'b1; e.b5 = 1'b1; e.b6 = 1'b1; e.mode2 = 1'b1;
        exp_jp(1, 0, e, "six_port0");
        exp_jp(1, 1, '0, "six_port1");
        vs_pulse();
        six_btn     = 2'b10;
        joystick[0] = 32'h0000_00C0;
        joystick[1] = 32'h0000_0FC0;
        e = '0; e.select = 1'b1; e.run = 1'b1;
        exp_jp(1, 0, e, "sel_run_port0");
        e.b3 = 1'b1; e.b4 = 1'b1; e.b5 = 1'b1; e.b6 = 1'b1; e.mode2 = 1'b1;
        exp_jp(1, 1, e, "sel_run_six_port1");
        vs_pulse();
        six_btn     = 2'b00;
        joystick[1] = '0;

        // Frame counter reads 7 through the phase select
        turbo_rate = 2'd1; exp_ph(0, TURBO, "fc7_bit0"); tick();
        turbo_rate = 2'd2; exp_ph(0, TURBO, "fc7_bit1"); tick();
        turbo_rate = 2'd3; exp_ph(0, TURBO, "fc7_bit2"); tick();
        turbo_rate = 2'd0;

        // vsync held high 10 cycles: one load, counter 7 -> 0
        joystick[0] = 32'h0000_0001;
        vsync = 1'b1;
        e = '0; e.r = 1'b1;
        exp_jp(1, 0, e, "hold_edge_load");
        tick();
        joystick[0] = 32'h0000_0002;
        repeat (9) tick();
        vsync = 1'b0;
        exp_jp(0, 0, e, "hold_single_load");
        tick();
        turbo_rate = 2'd1; exp_ph(0, 1'b0, "hold_fc_bit0"); tick();
        turbo_rate = 2'd2; exp_ph(0, 1'b0, "hold_fc_bit1"); tick();
        turbo_rate = 2'd3; exp_ph(0, 1'b0, "hold_fc_bit2"); tick();

        // Reset with jp nonzero and counter at 1
        turbo_rate  = 2'd1;
        joystick[0] = 32'h0000_0001;
        exp_jp(1, 0, e, "pre_reset_load");
        vs_pulse();
        exp_ph(0, TURBO, "fc_one");
        reset = 1'b1;
        exp_jp(1, 0, '0, "rst_mid_jp0");
        exp_ph(1, 1'b0, "rst_mid_fc0");
        tick();
        exp_jp(1, 0, '0, "rst_vsync_jp0");
        vs_pulse();
        reset = 1'b0;
        tick();
        exp_ph(0, 1'b0, "rst_vsync_ignored");
        exp_jp(0, 0, '0, "post_rst_jp0");
        tick();

        // Turbo rate 2 over 16 frames: b1 0,0,1,1 repeating
        turbo_rate  = 2'd2;
        joystick[0] = 32'h0000_1000;
        pat = 4'b1100;
        for (int i = 0; i < 16; i++) begin
            e = '0; e.b1 = TURBO & pat[i % 4];
            exp_jp(1, 0, e, $sformatf("turbo_r2_f%0d", i));
            vs_pulse();
        end
        // Rate change applies at the next update without resetting the counter (fc 0)
        turbo_rate = 2'd1;
        pat1 = 2'b10;
        for (int i = 0; i < 2; i++) begin
            e = '0; e.b1 = TURBO & pat1[i];
            exp_jp(1, 0, e, $sformatf("turbo_r1_f%0d", i));
            vs_pulse();
        end
        turbo_rate = 2'd0;
        exp_jp(1, 0, '0, "turbo_off");
        vs_pulse();
        // Rate 3 with turbo on b2: counter 3 then 4
        turbo_rate  = 2'd3;
        joystick[0] = 32'h0000_2000;
        exp_jp(1, 0, '0, "turbo_r3_fc3");
        vs_pulse();
        e = '0; e.b2 = TURBO;
        exp_jp(1, 0, e, "turbo_r3_fc4");
        vs_pulse();
        turbo_rate  = 2'd0;
        joystick[0] = 32'h0000_1010;
        e = '0; e.b1 = 1'b1;
        exp_jp(1, 0, e, "plain_b1_with_turbo_bit");
        vs_pulse();

        // Every-cycle instance follows with one cycle of latency
        nl_vals = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            joystick[0] = 32'(1) << k;
            e = '0;
            case (k)
                0: e.r = 1'b1;
                1: e.l = 1'b1;
                2: e.d = 1'b1;
                default: e.u = 1'b1;
            endcase
            exp_nl(1, 0, e, $sformatf("nl_track_%0d", k));
            tick();
        end
        e = '0; e.b1 = 1'b1;
        exp_jp(0, 0, e, "latched_holds");
        tick();

        begin
            int guard;
            guard = 0;
            while (q.size() > 0 && guard < 20) begin
                tick();
                guard++;
            end
            if (q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d checks pending, required 0", q.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
